// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle AND/OR/ADD/SUB/SLL with registered outputs, plus an
// iterative shift-add multiplier that occupies the unit for XLEN cycles.
module alu_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alucontrol,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);
    localparam int SHW = $clog2(XLEN);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b1110;
    localparam logic [3:0] OP_MUL = 4'b0100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [XLEN-1:0] mcand_reg, mplier_reg, acc_reg;
    logic [SHW-1:0]  count_reg;
    logic [XLEN-1:0] addend, acc_sum;
    logic [XLEN-1:0] result_reg, single_result;
    logic            out_valid_reg, zero_reg, illegal_reg, single_illegal;
    logic            fire_in, fire_out, is_mul, mul_done;

    assign fire_in  = in_valid && in_ready;
    assign fire_out = out_valid_reg && out_ready;
    assign is_mul   = (alucontrol == OP_MUL);
    assign mul_done = (state_reg == S_MUL) && (count_reg == SHW'(XLEN - 1));

    // Partial product for this iteration: multiplicand gated by the current multiplier LSB.
    genvar gi;
    generate
        for (gi = 0; gi < XLEN; gi++) begin : g_addend
            assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
        end
    endgenerate

    assign acc_sum = acc_reg + addend;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (fire_in && is_mul) state_next = S_MUL;
            S_MUL:   if (mul_done) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_reg == S_IDLE) && (!out_valid_reg || out_ready);
    end

    always_comb begin
        single_result  = '0;
        single_illegal = 1'b0;
        case (alucontrol)
            OP_AND:  single_result = op_a & op_b;
            OP_OR:   single_result = op_a | op_b;
            OP_ADD:  single_result = op_a + op_b;
            OP_SUB:  single_result = op_a + ~op_b + 1'b1;
            OP_SLL:  single_result = op_a << op_b[SHW-1:0];
            default: single_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            count_reg  <= '0;
        end else if (fire_in && is_mul) begin
            mcand_reg  <= op_a;
            mplier_reg <= op_b;
            acc_reg    <= '0;
            count_reg  <= '0;
        end else if (state_reg == S_MUL) begin
            acc_reg    <= acc_sum;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            count_reg  <= count_reg + SHW'(1);
        end
    end

    // A same-cycle accept of a single-cycle op keeps out_valid high for back-to-back issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            zero_reg      <= 1'b0;
            illegal_reg   <= 1'b0;
        end else if (fire_in && !is_mul) begin
            out_valid_reg <= 1'b1;
            result_reg    <= single_result;
            zero_reg      <= (single_result == '0);
            illegal_reg   <= single_illegal;
        end else if (mul_done) begin
            out_valid_reg <= 1'b1;
            result_reg    <= acc_sum;
            zero_reg      <= (acc_sum == '0);
            illegal_reg   <= 1'b0;
        end else if (fire_out) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign zero      = zero_reg;
    assign illegal   = illegal_reg;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vector table, handshake corner sequences,
// and randomized ops against a plain-arithmetic reference model.
module tb_alu_exec_unit;
    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alucontrol;
    logic [31:0] op_a, op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int n_vec = 0;
    int n_err = 0;

    alu_exec_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .alucontrol(alucontrol), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        z;
        logic        il;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    function automatic void ref_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output logic z, output logic il);
        int sh;
        il = 1'b0;
        sh = int'(b % 32);
        case (c)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b1110: r = a * (32'd1 << sh);
            4'b0100: r = a * b;
            default: begin r = 32'd0; il = 1'b1; end
        endcase
        z = (r == 32'd0);
    endfunction

    // Issue one op with out_ready=1 and wait for its result; lat counts cycles accept->out_valid.
    task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic z, output logic il, output int lat);
        int k;
        k = 0;
        out_ready = 1'b1;
        while (!in_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL in_ready_timeout: got 0, expected 1");
        end
        alucontrol = c; op_a = a; op_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        r = result; z = zero; il = illegal;
    endtask

    initial begin
        logic [31:0] r, er;
        logic        z, il, ez, eil;
        logic [3:0]  codes[8];
        logic [3:0]  c;
        logic [31:0] a, b;
        int          lat, cyc, bad, seen;

        tbl[0]  = '{4'b0010, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0};
        tbl[1]  = '{4'b0110, 32'd9,          32'd9,          32'd0,          1'b1, 1'b0};
        tbl[2]  = '{4'b1110, 32'd1,          32'd33,         32'd2,          1'b0, 1'b0};
        tbl[3]  = '{4'b0001, 32'h000000F0,   32'h0000000F,   32'h000000FF,   1'b0, 1'b0};
        tbl[4]  = '{4'b0000, 32'hF0F0_1234,  32'h0FF0_FF00,  32'h00F0_1200,  1'b0, 1'b0};
        tbl[5]  = '{4'b0100, 32'hFFFF_FFFF,  32'd3,          32'hFFFF_FFFD,  1'b0, 1'b0};
        tbl[6]  = '{4'b0011, 32'd123,        32'd456,        32'd0,          1'b1, 1'b1};
        tbl[7]  = '{4'b0010, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0};
        tbl[8]  = '{4'b0110, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0, 1'b0};
        tbl[9]  = '{4'b1110, 32'd1,          32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 1'b0};
        tbl[10] = '{4'b0100, 32'd0,          32'h1234_5678,  32'd0,          1'b1, 1'b0};
        tbl[11] = '{4'b0100, 32'd12345,      32'd6789,       32'd83810205,   1'b0, 1'b0};

        codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1110, 4'b0100, 4'b0011, 4'b1111};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        alucontrol = 4'b0000; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        reset = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i].c, tbl[i].a, tbl[i].b, r, z, il, lat);
            check($sformatf("tbl%0d_result", i), r, tbl[i].r);
            check($sformatf("tbl%0d_zero", i), 32'(z), 32'(tbl[i].z));
            check($sformatf("tbl%0d_illegal", i), 32'(il), 32'(tbl[i].il));
            check($sformatf("tbl%0d_latency", i), 32'(lat), (tbl[i].c == 4'b0100) ? 32'd33 : 32'd1);
        end

        // Back-to-back SUB then SLL at one op per cycle.
        @(posedge clk); #1;
        alucontrol = 4'b0110; op_a = 32'd9; op_b = 32'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        check("b2b_sub_valid", 32'(out_valid), 32'd1);
        check("b2b_sub_result", result, 32'd0);
        check("b2b_sub_zero", 32'(zero), 32'd1);
        check("b2b_in_ready", 32'(in_ready), 32'd1);
        alucontrol = 4'b1110; op_a = 32'd1; op_b = 32'd33;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b_sll_valid", 32'(out_valid), 32'd1);
        check("b2b_sll_result", result, 32'd2);
        check("b2b_sll_zero", 32'(zero), 32'd0);
        @(posedge clk); #1;
        check("b2b_drained", 32'(out_valid), 32'd0);

        // MUL busy window: in_ready must stay low until the result appears.
        alucontrol = 4'b0100; op_a = 32'hFFFF_FFFF; op_b = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0; bad = 0;
        while (!out_valid && cyc < 100) begin
            if (in_ready) bad++;
            @(posedge clk); #1;
            cyc++;
        end
        check("mul_busy_cycles", 32'(cyc), 32'd32);
        check("mul_in_ready_high", 32'(bad), 32'd0);
        check("mul_result", result, 32'hFFFF_FFFD);
        @(posedge clk); #1;

        // Backpressure: result held for 5 cycles, a blocked op is ignored, then drains in 1 cycle.
        out_ready = 1'b0;
        alucontrol = 4'b0001; op_a = 32'hF0; op_b = 32'h0F; in_valid = 1'b1;
        @(posedge clk); #1;
        alucontrol = 4'b0010; op_a = 32'd100; op_b = 32'd200;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold%0d_result", i), result, 32'h0000_00FF);
            check($sformatf("hold%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("hold%0d_in_ready", i), 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("hold_drain_valid", 32'(out_valid), 32'd0);
        check("hold_drain_in_ready", 32'(in_ready), 32'd1);
        check("hold_drain_result", result, 32'h0000_00FF);

        // Reset during MUL aborts it with nothing emitted.
        alucontrol = 4'b0100; op_a = 32'd7; op_b = 32'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_result", result, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("abort_no_emit", 32'(seen), 32'd0);
        run_op(4'b0010, 32'd1, 32'd1, r, z, il, lat);
        check("abort_add_result", r, 32'd2);

        // Illegal code then a legal op clears the flag.
        run_op(4'b0011, 32'd5, 32'd5, r, z, il, lat);
        check("illegal_flag", 32'(il), 32'd1);
        check("illegal_zero", 32'(z), 32'd1);
        run_op(4'b0000, 32'hFF, 32'h0F, r, z, il, lat);
        check("illegal_cleared", 32'(il), 32'd0);
        check("illegal_next_result", r, 32'h0F);

        // Randomized ops against the reference model.
        for (int i = 0; i < 150; i++) begin
            c = codes[$urandom_range(0, 7)];
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            ref_model(c, a, b, er, ez, eil);
            run_op(c, a, b, r, z, il, lat);
            check($sformatf("rnd%0d_c%b_result", i, c), r, er);
            check($sformatf("rnd%0d_zero", i), 32'(z), 32'(ez));
            check($sformatf("rnd%0d_illegal", i), 32'(il), 32'(eil));
            check($sformatf("rnd%0d_latency", i), 32'(lat), (c == 4'b0100) ? 32'd33 : 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
